axi_lite_strb_ram: RTL and testbench

AXI_LITE_STRB_RAM -- requirements
Module: axi_lite_strb_ram

---
 rtl/axi_lite_strb_ram.sv | 163 ++++++++++++++++
 tb/tb_axi_lite_strb_ram.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_strb_ram.sv
// AXI4-Lite slave backed by a byte-strobed word RAM.
// Independent read and write engines; memory contents survive reset.
module axi_lite_strb_ram #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 2048
) (
   input  logic                    aclk,
   input  logic                    areset_n,
   input  logic [ADDR_WIDTH-1:0]   awaddr,
   input  logic                    awvalid,
   output logic                    awready,
   input  logic [DATA_WIDTH-1:0]   wdata,
   input  logic [DATA_WIDTH/8-1:0] wstrb,
   input  logic                    wvalid,
   output logic                    wready,
   output logic [1:0]              bresp,
   output logic                    bvalid,
   input  logic                    bready,
   input  logic [ADDR_WIDTH-1:0]   araddr,
   input  logic                    arvalid,
   output logic                    arready,
   output logic [DATA_WIDTH-1:0]   rdata,
   output logic [1:0]              rresp,
   output logic                    rvalid,
   input  logic                    rready
);

   localparam int SW  = DATA_WIDTH / 8;
   localparam int OFF = $clog2(SW);
   localparam int IW  = ADDR_WIDTH - OFF;
   localparam int LD  = $clog2(DEPTH);

   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;

   typedef enum logic { W_IDLE, W_RESP } w_state_t;
   typedef enum logic { R_IDLE, R_DATA } r_state_t;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   function automatic logic in_range(input logic [IW-1:0] idx);
      return (idx >> LD) == '0;
   endfunction

   // Holds the readies low until the first edge after reset release.
   logic active;

   always_ff @(posedge aclk) begin
      if (!areset_n) active <= 1'b0;
      else           active <= 1'b1;
   end

   w_state_t              w_state;
   logic                  aw_held;
   logic                  w_held;
   logic [ADDR_WIDTH-1:0] aw_addr_q;
   logic [DATA_WIDTH-1:0] w_data_q;
   logic [SW-1:0]         w_strb_q;

   logic                  aw_hs;
   logic                  w_hs;
   logic                  commit;
   logic [ADDR_WIDTH-1:0] wa;
   logic [DATA_WIDTH-1:0] wd;
   logic [SW-1:0]         ws;
   logic [IW-1:0]         w_idx;
   logic                  w_ok;

   assign awready = active && (w_state == W_IDLE) && !aw_held;
   assign wready  = active && (w_state == W_IDLE) && !w_held;
   assign bvalid  = (w_state == W_RESP);

   assign aw_hs = awvalid && awready;
   assign w_hs  = wvalid && wready;

   assign wa    = aw_held ? aw_addr_q : awaddr;
   assign wd    = w_held ? w_data_q : wdata;
   assign ws    = w_held ? w_strb_q : wstrb;
   assign w_idx = wa[ADDR_WIDTH-1:OFF];
   assign w_ok  = in_range(w_idx);

   assign commit = areset_n && (w_state == W_IDLE)
                 && (aw_held || aw_hs) && (w_held || w_hs);

   always_ff @(posedge aclk) begin
      if (commit && w_ok) begin
         for (int i = 0; i < SW; i++) begin
            if (ws[i]) mem[w_idx[LD-1:0]][8*i +: 8] <= wd[8*i +: 8];
         end
      end
   end

   always_ff @(posedge aclk) begin
      if (!areset_n) begin
         w_state <= W_IDLE;
         aw_held <= 1'b0;
         w_held  <= 1'b0;
         bresp   <= OKAY;
      end else begin
         unique case (w_state)
            W_IDLE: begin
               if (commit) begin
                  aw_held <= 1'b0;
                  w_held  <= 1'b0;
                  bresp   <= w_ok ? OKAY : SLVERR;
                  w_state <= W_RESP;
               end else begin
                  if (aw_hs) begin
                     aw_held   <= 1'b1;
                     aw_addr_q <= awaddr;
                  end
                  if (w_hs) begin
                     w_held   <= 1'b1;
                     w_data_q <= wdata;
                     w_strb_q <= wstrb;
                  end
               end
            end
            W_RESP: begin
               if (bready) w_state <= W_IDLE;
            end
         endcase
      end
   end

   r_state_t      r_state;
   logic          ar_hs;
   logic [IW-1:0] r_idx;
   logic          r_ok;

   assign arready = active && (r_state == R_IDLE);
   assign rvalid  = (r_state == R_DATA);
   assign ar_hs   = arvalid && arready;
   assign r_idx   = araddr[ADDR_WIDTH-1:OFF];
   assign r_ok    = in_range(r_idx);

   // Same-edge write commit is not visible here: the read samples old data.
   always_ff @(posedge aclk) begin
      if (!areset_n) begin
         r_state <= R_IDLE;
         rdata   <= '0;
         rresp   <= OKAY;
      end else begin
         unique case (r_state)
            R_IDLE: begin
               if (ar_hs) begin
                  rdata   <= r_ok ? mem[r_idx[LD-1:0]] : '0;
                  rresp   <= r_ok ? OKAY : SLVERR;
                  r_state <= R_DATA;
               end
            end
            R_DATA: begin
               if (rready) r_state <= R_IDLE;
            end
         endcase
      end
   end

   logic unused_ok;
   assign unused_ok = ^{wa[OFF-1:0], araddr[OFF-1:0]};

endmodule

// File: tb/tb_axi_lite_strb_ram.sv
// Directed checks for axi_lite_strb_ram at default parameters.
// Inputs change and outputs are sampled on the falling edge.
module tb_axi_lite_strb_ram;

   logic        aclk = 1'b0;
   logic        areset_n;
   logic [31:0] awaddr;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;
   logic [31:0] araddr;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;

   int n_run  = 0;
   int n_fail = 0;

   always #5 aclk = ~aclk;

   axi_lite_strb_ram dut (
      .aclk     (aclk),
      .areset_n (areset_n),
      .awaddr   (awaddr),
      .awvalid  (awvalid),
      .awready  (awready),
      .wdata    (wdata),
      .wstrb    (wstrb),
      .wvalid   (wvalid),
      .wready   (wready),
      .bresp    (bresp),
      .bvalid   (bvalid),
      .bready   (bready),
      .araddr   (araddr),
      .arvalid  (arvalid),
      .arready  (arready),
      .rdata    (rdata),
      .rresp    (rresp),
      .rvalid   (rvalid),
      .rready   (rready)
   );

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // mode 0: AW then W two cycles later, 1: W then AW, 2: same cycle
   task automatic wr(input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, input int mode,
                     input logic [1:0] exp_resp, input string tag);
      if (mode == 2) begin
         awaddr = a; awvalid = 1'b1;
         wdata = d; wstrb = s; wvalid = 1'b1;
         @(negedge aclk);
         awvalid = 1'b0; wvalid = 1'b0;
      end else begin
         if (mode == 0) begin
            awaddr = a; awvalid = 1'b1;
         end else begin
            wdata = d; wstrb = s; wvalid = 1'b1;
         end
         @(negedge aclk);
         awvalid = 1'b0; wvalid = 1'b0;
         chk({tag, ".half_no_b"}, 64'(bvalid), 64'd0);
         chk({tag, ".half_rdy"}, 64'(mode == 0 ? awready : wready), 64'd0);
         @(negedge aclk);
         if (mode == 0) begin
            wdata = d; wstrb = s; wvalid = 1'b1;
         end else begin
            awaddr = a; awvalid = 1'b1;
         end
         @(negedge aclk);
         awvalid = 1'b0; wvalid = 1'b0;
      end
      chk({tag, ".bvalid"}, 64'(bvalid), 64'd1);
      chk({tag, ".bresp"}, 64'(bresp), 64'(exp_resp));
      bready = 1'b1;
      @(negedge aclk);
      bready = 1'b0;
      chk({tag, ".b_done"}, 64'(bvalid), 64'd0);
   endtask

   task automatic rd(input logic [31:0] a, input logic [31:0] exp_d,
                     input logic [1:0] exp_resp, input string tag);
      araddr = a; arvalid = 1'b1;
      @(negedge aclk);
      arvalid = 1'b0;
      chk({tag, ".rvalid"}, 64'(rvalid), 64'd1);
      chk({tag, ".rdata"}, 64'(rdata), 64'(exp_d));
      chk({tag, ".rresp"}, 64'(rresp), 64'(exp_resp));
      rready = 1'b1;
      @(negedge aclk);
      rready = 1'b0;
      chk({tag, ".r_done"}, 64'(rvalid), 64'd0);
   endtask

   initial begin
      areset_n = 1'b0;
      awaddr = '0; awvalid = 1'b0;
      wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
      araddr = '0; arvalid = 1'b0; rready = 1'b0;
      repeat (3) @(negedge aclk);

      chk("rst.awready", 64'(awready), 64'd0);
      chk("rst.wready", 64'(wready), 64'd0);
      chk("rst.arready", 64'(arready), 64'd0);
      chk("rst.bvalid", 64'(bvalid), 64'd0);
      chk("rst.rvalid", 64'(rvalid), 64'd0);
      chk("rst.bresp", 64'(bresp), 64'd0);
      chk("rst.rresp", 64'(rresp), 64'd0);
      chk("rst.rdata", 64'(rdata), 64'd0);

      areset_n = 1'b1;
      @(negedge aclk);
      chk("rel.awready", 64'(awready), 64'd1);
      chk("rel.wready", 64'(wready), 64'd1);
      chk("rel.arready", 64'(arready), 64'd1);

      wr(32'h10, 32'hDEADBEEF, 4'hF, 0, 2'b00, "aw_first");
      rd(32'h10, 32'hDEADBEEF, 2'b00, "rd_full");

      wr(32'h10, 32'h11223344, 4'h5, 1, 2'b00, "w_first");
      rd(32'h10, 32'hDE22BE44, 2'b00, "rd_strb");
      rd(32'h13, 32'hDE22BE44, 2'b00, "rd_offset");

      wr(32'h10, 32'hFFFFFFFF, 4'h0, 2, 2'b00, "strb0");
      rd(32'h10, 32'hDE22BE44, 2'b00, "rd_strb0");

      wr(32'h0, 32'hA5A5A5A5, 4'hF, 2, 2'b00, "w_word0");
      wr(32'h1FFC, 32'h5A5A5A5A, 4'hF, 2, 2'b00, "w_last");
      wr(32'h2000, 32'hFFFFFFFF, 4'hF, 2, 2'b10, "w_oor");
      rd(32'h2000, 32'h0, 2'b10, "rd_oor");
      rd(32'h0, 32'hA5A5A5A5, 2'b00, "rd_word0");
      rd(32'h1FFC, 32'h5A5A5A5A, 2'b00, "rd_last");

      wr(32'h20, 32'h0, 4'hF, 2, 2'b00, "w_clr20");
      awaddr = 32'h20; awvalid = 1'b1;
      wdata = 32'hCAFEF00D; wstrb = 4'hF; wvalid = 1'b1;
      araddr = 32'h20; arvalid = 1'b1;
      @(negedge aclk);
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("stall.bvalid", 64'(bvalid), 64'd1);
         chk("stall.rvalid", 64'(rvalid), 64'd1);
         chk("stall.rdata", 64'(rdata), 64'd0);
         chk("stall.awready", 64'(awready), 64'd0);
         @(negedge aclk);
      end
      bready = 1'b1; rready = 1'b1;
      @(negedge aclk);
      bready = 1'b0; rready = 1'b0;
      chk("stall.b_done", 64'(bvalid), 64'd0);
      chk("stall.r_done", 64'(rvalid), 64'd0);
      rd(32'h20, 32'hCAFEF00D, 2'b00, "rd_new20");

      wr(32'h40, 32'h11111111, 4'hF, 2, 2'b00, "w_40");
      awaddr = 32'h30; awvalid = 1'b1;
      wdata = 32'h12345678; wvalid = 1'b1;
      araddr = 32'h30; arvalid = 1'b1;
      @(negedge aclk);
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      chk("mid.bvalid", 64'(bvalid), 64'd1);
      chk("mid.rvalid", 64'(rvalid), 64'd1);
      areset_n = 1'b0;
      @(negedge aclk);
      chk("mid_rst.bvalid", 64'(bvalid), 64'd0);
      chk("mid_rst.rvalid", 64'(rvalid), 64'd0);
      chk("mid_rst.awready", 64'(awready), 64'd0);
      areset_n = 1'b1;
      @(negedge aclk);
      chk("post.awready", 64'(awready), 64'd1);
      chk("post.wready", 64'(wready), 64'd1);
      chk("post.arready", 64'(arready), 64'd1);

      awaddr = 32'h40; awvalid = 1'b1;
      @(negedge aclk);
      awvalid = 1'b0;
      chk("held.awready", 64'(awready), 64'd0);
      areset_n = 1'b0;
      @(negedge aclk);
      areset_n = 1'b1;
      @(negedge aclk);
      chk("held_rst.awready", 64'(awready), 64'd1);
      wdata = 32'h22222222; wstrb = 4'hF; wvalid = 1'b1;
      @(negedge aclk);
      wvalid = 1'b0;
      @(negedge aclk);
      chk("held_rst.no_b", 64'(bvalid), 64'd0);
      awaddr = 32'h44; awvalid = 1'b1;
      @(negedge aclk);
      awvalid = 1'b0;
      chk("w_44.bvalid", 64'(bvalid), 64'd1);
      bready = 1'b1;
      @(negedge aclk);
      bready = 1'b0;
      rd(32'h40, 32'h11111111, 2'b00, "rd_40");
      rd(32'h44, 32'h22222222, 2'b00, "rd_44");
      rd(32'h30, 32'h12345678, 2'b00, "rd_30");

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
